// File: rtl/mem_wb_stage.sv
// Memory-to-writeback pipeline stage with a two-entry skid buffer.
// HEAD drives the writeback port and the forwarding flag. SKID absorbs one
// extra instruction while writeback stalls. A 64-bit counter tracks retired
// instructions.
//
// Handshake contract, for both ports: a transfer happens on a rising edge
// where valid and ready are both high. A producer holding valid keeps its
// payload stable until the transfer. in_ready depends only on registered
// state, so it has no combinational path from wb_ready.
module mem_wb_stage #(
   parameter int unsigned       XLEN          = 64,
   parameter int unsigned       REG_ADDRWIDTH = 5,
   parameter logic [XLEN-1:0]   PC_RESET_ADDR = 64'h8000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [XLEN-1:0]          in_pc,
   input  logic [REG_ADDRWIDTH-1:0] in_rd_idx,
   input  logic                     in_rd_wen,
   input  logic [XLEN-1:0]          in_exc,
   input  logic [XLEN-1:0]          in_mem_out,
   input  logic                     in_is_load,
   input  logic                     flush,
   output logic                     wb_valid,
   input  logic                     wb_ready,
   output logic [XLEN-1:0]          wb_pc,
   output logic [REG_ADDRWIDTH-1:0] wb_rd_idx,
   output logic                     wb_rd_wen,
   output logic [XLEN-1:0]          wb_data,
   output logic                     fwd_valid,
   output logic [63:0]              instret
);

   // Occupancy: EMPTY = no entries, ONE = HEAD only, FULL = HEAD and SKID.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   state_e                   state_q, state_d;
   logic [XLEN-1:0]          head_pc_q, head_pc_d, head_data_q, head_data_d;
   logic [REG_ADDRWIDTH-1:0] head_rd_q, head_rd_d;
   logic                     head_wen_q, head_wen_d;
   logic [XLEN-1:0]          skid_pc_q, skid_pc_d, skid_data_q, skid_data_d;
   logic [REG_ADDRWIDTH-1:0] skid_rd_q, skid_rd_d;
   logic                     skid_wen_q, skid_wen_d;
   logic [63:0]              instret_q, instret_d;

   logic                     accept, pop, cap_wen;
   logic [XLEN-1:0]          cap_data;

   // Output view of HEAD; idle values are forced whenever HEAD is empty.
   always_comb begin
      in_ready  = (state_q != ST_FULL);
      wb_valid  = (state_q != ST_EMPTY);
      wb_pc     = wb_valid ? head_pc_q   : PC_RESET_ADDR;
      wb_rd_idx = wb_valid ? head_rd_q   : '0;
      wb_rd_wen = wb_valid ? head_wen_q  : 1'b0;
      wb_data   = wb_valid ? head_data_q : '0;
      fwd_valid = wb_valid & head_wen_q;
      instret   = instret_q;
   end

   // Handshake decode and capture formatting (x0 is never written).
   always_comb begin
      accept   = in_valid & in_ready;
      pop      = wb_valid & wb_ready;
      cap_data = in_is_load ? in_mem_out : in_exc;
      cap_wen  = in_rd_wen & (in_rd_idx != '0);
   end

   // Next-state and entry movement; flush overrides any accept.
   always_comb begin
      state_d     = state_q;
      head_pc_d   = head_pc_q;
      head_rd_d   = head_rd_q;
      head_wen_d  = head_wen_q;
      head_data_d = head_data_q;
      skid_pc_d   = skid_pc_q;
      skid_rd_d   = skid_rd_q;
      skid_wen_d  = skid_wen_q;
      skid_data_d = skid_data_q;
      instret_d   = instret_q + {63'd0, pop};
      unique case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               head_pc_d   = in_pc;
               head_rd_d   = in_rd_idx;
               head_wen_d  = cap_wen;
               head_data_d = cap_data;
               state_d     = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && pop) begin
               head_pc_d   = in_pc;
               head_rd_d   = in_rd_idx;
               head_wen_d  = cap_wen;
               head_data_d = cap_data;
            end else if (accept) begin
               skid_pc_d   = in_pc;
               skid_rd_d   = in_rd_idx;
               skid_wen_d  = cap_wen;
               skid_data_d = cap_data;
               state_d     = ST_FULL;
            end else if (pop) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (pop) begin
               head_pc_d   = skid_pc_q;
               head_rd_d   = skid_rd_q;
               head_wen_d  = skid_wen_q;
               head_data_d = skid_data_q;
               state_d     = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (flush) begin
         state_d = ST_EMPTY;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_EMPTY;
         head_pc_q   <= PC_RESET_ADDR;
         head_rd_q   <= '0;
         head_wen_q  <= 1'b0;
         head_data_q <= '0;
         skid_pc_q   <= PC_RESET_ADDR;
         skid_rd_q   <= '0;
         skid_wen_q  <= 1'b0;
         skid_data_q <= '0;
         instret_q   <= '0;
      end else begin
         state_q     <= state_d;
         head_pc_q   <= head_pc_d;
         head_rd_q   <= head_rd_d;
         head_wen_q  <= head_wen_d;
         head_data_q <= head_data_d;
         skid_pc_q   <= skid_pc_d;
         skid_rd_q   <= skid_rd_d;
         skid_wen_q  <= skid_wen_d;
         skid_data_q <= skid_data_d;
         instret_q   <= instret_d;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed scenario tasks plus a scoreboard
// that follows every accept and pop, and compares each output cycle.
module tb_mem_wb_stage;

   localparam int          W       = 64 + 5 + 1 + 64;
   localparam logic [63:0] PC_RST  = 64'h8000_0000;

   logic        clk, rst;
   logic        in_valid, in_ready, in_rd_wen, in_is_load, flush;
   logic [63:0] in_pc, in_exc, in_mem_out;
   logic [4:0]  in_rd_idx;
   logic        wb_valid, wb_ready, wb_rd_wen, fwd_valid;
   logic [63:0] wb_pc, wb_data, instret;
   logic [4:0]  wb_rd_idx;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];
   logic [63:0]  exp_instret = '0;

   mem_wb_stage dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_rd_idx(in_rd_idx), .in_rd_wen(in_rd_wen), .in_exc(in_exc),
      .in_mem_out(in_mem_out), .in_is_load(in_is_load), .flush(flush),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc),
      .wb_rd_idx(wb_rd_idx), .wb_rd_wen(wb_rd_wen), .wb_data(wb_data),
      .fwd_valid(fwd_valid), .instret(instret)
   );

   // Clock and reset defaults.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard: checks the cycle's outputs on the falling edge, then models
   // the accept/pop/flush that the coming rising edge will perform.
   always @(negedge clk) begin
      logic         acc, pp;
      logic [W-1:0] act;
      if (!rst) begin
         exp_q.delete();
         exp_instret = '0;
      end else begin
         checks++;
         if (in_ready !== (exp_q.size() < 2)) begin
            errors++;
            $display("FAIL sb_in_ready: got %b want %b", in_ready, exp_q.size() < 2);
         end
         checks++;
         if (wb_valid !== (exp_q.size() > 0)) begin
            errors++;
            $display("FAIL sb_wb_valid: got %b want %b", wb_valid, exp_q.size() > 0);
         end
         checks++;
         if (instret !== exp_instret) begin
            errors++;
            $display("FAIL sb_instret: got %0d want %0d", instret, exp_instret);
         end
         checks++;
         if (exp_q.size() > 0) begin
            act = {wb_pc, wb_rd_idx, wb_rd_wen, wb_data};
            if (act !== exp_q[0] || fwd_valid !== exp_q[0][64]) begin
               errors++;
               $display("FAIL sb_head: got %h fwd %b want %h", act, fwd_valid, exp_q[0]);
            end
         end else if (wb_pc !== PC_RST || wb_data !== '0 || wb_rd_idx !== '0 ||
                      wb_rd_wen !== 1'b0 || fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL sb_idle: got pc %h data %h rd %0d wen %b fwd %b",
                     wb_pc, wb_data, wb_rd_idx, wb_rd_wen, fwd_valid);
         end
         pp  = (exp_q.size() > 0) && wb_ready;
         acc = in_valid && (exp_q.size() < 2);
         if (pp) begin
            void'(exp_q.pop_front());
            exp_instret = exp_instret + 64'd1;
         end
         if (flush) exp_q.delete();
         else if (acc)
            exp_q.push_back({in_pc, in_rd_idx, in_rd_wen && (in_rd_idx != 5'd0),
                             in_is_load ? in_mem_out : in_exc});
      end
   end

   // Driver tasks.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_in(input logic [63:0] pc, input logic [4:0] rd, input logic wen,
                           input logic [63:0] exc, input logic [63:0] mem, input logic ld);
      in_valid = 1'b1; in_pc = pc; in_rd_idx = rd; in_rd_wen = wen;
      in_exc = exc; in_mem_out = mem; in_is_load = ld;
   endtask

   task automatic drive_rand(input logic [63:0] pc);
      drive_in(pc, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   // Scenario tasks.
   task automatic test_reset();
      rst = 1'b0; in_valid = 0; in_pc = 0; in_rd_idx = 0; in_rd_wen = 0;
      in_exc = 0; in_mem_out = 0; in_is_load = 0; flush = 0; wb_ready = 0;
      step(); step();
      rst = 1'b1;
      checks++;
      if (wb_valid !== 1'b0 || wb_pc !== PC_RST || wb_data !== '0 || wb_rd_idx !== '0 ||
          wb_rd_wen !== 1'b0 || instret !== '0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset: valid %b pc %h data %h rd %0d wen %b instret %0d rdy %b",
                  wb_valid, wb_pc, wb_data, wb_rd_idx, wb_rd_wen, instret, in_ready);
      end
   endtask

   task automatic test_single_load();
      wb_ready = 1'b1;
      drive_in(64'h40, 5'd5, 1'b1, 64'h1234, 64'hFFFF_FFFF_FFFF_FF80, 1'b1);
      step();
      in_valid = 1'b0;
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== 64'hFFFF_FFFF_FFFF_FF80 || wb_rd_idx !== 5'd5 ||
          fwd_valid !== 1'b1) begin
         errors++;
         $display("FAIL load_out: valid %b data %h rd %0d fwd %b", wb_valid, wb_data,
                  wb_rd_idx, fwd_valid);
      end
      step();
      checks++;
      if (instret !== 64'd1) begin
         errors++;
         $display("FAIL load_instret: got %0d want 1", instret);
      end
   endtask

   task automatic test_x0();
      drive_in(64'h44, 5'd0, 1'b1, 64'd7, 64'hDEAD, 1'b0);
      step();
      in_valid = 1'b0;
      checks++;
      if (wb_valid !== 1'b1 || wb_rd_wen !== 1'b0 || fwd_valid !== 1'b0 || wb_data !== 64'd7) begin
         errors++;
         $display("FAIL x0_out: valid %b wen %b fwd %b data %h", wb_valid, wb_rd_wen,
                  fwd_valid, wb_data);
      end
      step();
      checks++;
      if (instret !== 64'd2) begin
         errors++;
         $display("FAIL x0_instret: got %0d want 2", instret);
      end
   endtask

   task automatic test_back_pressure();
      wb_ready = 1'b0;
      drive_in(64'h100, 5'd1, 1'b1, 64'hA, 64'h0, 1'b0);
      step();
      drive_in(64'h104, 5'd2, 1'b1, 64'hB, 64'h0, 1'b0);
      step();
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || wb_pc !== 64'h100) begin
         errors++;
         $display("FAIL bp_full: rdy %b pc %h want 0 / 100", in_ready, wb_pc);
      end
      step();
      checks++;
      if (wb_pc !== 64'h100 || wb_data !== 64'hA) begin
         errors++;
         $display("FAIL bp_hold: pc %h data %h want 100 / a", wb_pc, wb_data);
      end
      wb_ready = 1'b1;
      step();
      checks++;
      if (wb_pc !== 64'h104 || in_ready !== 1'b1 || wb_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_order: pc %h rdy %b valid %b want 104 / 1 / 1", wb_pc, in_ready, wb_valid);
      end
      step();
      checks++;
      if (wb_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain: valid %b want 0", wb_valid);
      end
   endtask

   task automatic test_flush();
      wb_ready = 1'b0;
      drive_in(64'h200, 5'd3, 1'b1, 64'h1, 64'h0, 1'b0);
      step();
      drive_in(64'h204, 5'd4, 1'b1, 64'h2, 64'h0, 1'b0);
      step();
      drive_in(64'h208, 5'd6, 1'b1, 64'h3, 64'h0, 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      checks++;
      if (wb_valid !== 1'b0 || wb_pc !== PC_RST || in_ready !== 1'b1 || wb_data !== '0) begin
         errors++;
         $display("FAIL flush_full: valid %b pc %h rdy %b data %h", wb_valid, wb_pc, in_ready, wb_data);
      end
      drive_in(64'h300, 5'd7, 1'b1, 64'h4, 64'h0, 1'b0);
      step();
      drive_in(64'h304, 5'd8, 1'b1, 64'h5, 64'h0, 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      step();
      checks++;
      if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_accept: valid %b rdy %b want 0 / 1", wb_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      wb_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         drive_rand(64'h1000 + 64'(4 * i));
         step();
      end
      in_valid = 1'b0;
      step();
      wb_ready = 1'b0;
      drive_rand(64'h2000);
      step();
      drive_rand(64'h2004);
      step();
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || instret !== 64'd9) begin
         errors++;
         $display("FAIL mid_full: rdy %b instret %0d want 0 / 9", in_ready, instret);
      end
      do_reset();
      checks++;
      if (wb_valid !== 1'b0 || instret !== '0 || in_ready !== 1'b1 || wb_pc !== PC_RST) begin
         errors++;
         $display("FAIL mid_reset: valid %b instret %0d rdy %b pc %h", wb_valid, instret,
                  in_ready, wb_pc);
      end
   endtask

   task automatic test_back_to_back();
      wb_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         drive_rand(64'h4000 + 64'(4 * i));
         step();
         checks++;
         if (wb_valid !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_bubble: cycle %0d valid %b rdy %b", i, wb_valid, in_ready);
         end
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (instret !== 64'd1000 || wb_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_count: instret %0d valid %b want 1000 / 0", instret, wb_valid);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) != 0) drive_rand(64'h8000 + 64'(4 * i));
         else in_valid = 1'b0;
         wb_ready = 1'($urandom_range(0, 1));
         flush    = ($urandom_range(0, 19) == 0);
         step();
      end
      flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
      step(); step(); step();
   endtask

   task automatic test_instret_wrap();
      in_valid = 1'b0; wb_ready = 1'b1;
      step();
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.instret_q;
      step();
      drive_rand(64'h9000);
      step();
      in_valid = 1'b0;
      step();
      checks++;
      if (instret !== 64'd0) begin
         errors++;
         $display("FAIL instret_wrap: got %h want 0", instret);
      end
   endtask

   // Scenario sequence and final report.
   initial begin
      test_reset();
      test_single_load();
      test_x0();
      test_back_pressure();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_instret_wrap();
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
